booth_r4_multiplier: RTL and testbench

Parametrised radix-4 Booth sequential multiplier, successor to the team's fixed 64-bit radix-2 Booth multiplier. It retires two multiplier bits per clock, so a signed multiply takes WIDTH/2 cycles instead of WIDTH. It adds a per-operation signed/unsigned mode and a busy indication. It keeps the op_start / op_clear / op_done handshake so existing benches and controllers drive it unchanged.

---
 rtl/booth_r4_multiplier_if.sv | 24 ++
 rtl/booth_r4_multiplier.sv | 124 ++++++++++++
 tb/tb_booth_r4_multiplier.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_r4_multiplier_if.sv
// Operand/handshake bundle for booth_r4_multiplier.
// The controller drives the master side; the multiplier sits on the slave side.
interface booth_r4_multiplier_if #(
   parameter int unsigned WIDTH = 64
);
   logic [WIDTH-1:0]   multiplier;
   logic [WIDTH-1:0]   multiplicand;
   logic               op_signed;
   logic               op_start;
   logic               op_clear;
   logic [2*WIDTH-1:0] result;
   logic               op_done;
   logic               op_busy;

   modport master (
      output multiplier, multiplicand, op_signed, op_start, op_clear,
      input  result, op_done, op_busy
   );

   modport slave (
      input  multiplier, multiplicand, op_signed, op_start, op_clear,
      output result, op_done, op_busy
   );
endinterface

// File: rtl/booth_r4_multiplier.sv
// Radix-4 Booth sequential multiplier, two multiplier bits retired per cycle.
// Optional BOOTH_EARLY_TERM_EN: stop as soon as all remaining Booth digits are zero.
module booth_r4_multiplier #(
   parameter int unsigned WIDTH = 64
) (
   input logic                  clk,
   input logic                  reset_n,
   booth_r4_multiplier_if.slave bus
);
   localparam int unsigned EXT  = WIDTH + 2;
   localparam int unsigned ACC  = 2 * EXT;
   localparam int unsigned NSGN = WIDTH / 2;
   localparam int unsigned NUNS = WIDTH / 2 + 1;
   localparam int unsigned CW   = $clog2(NUNS + 1);
   localparam int unsigned SW   = $clog2(EXT + 1);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e             state_q;
   logic [ACC-1:0]     acc_q;
   logic [EXT-1:0]     mq_q;
   logic [EXT-1:0]     mcand_q;
   logic               lb_q;
   logic               signed_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] result_q;
   logic               done_q;
   logic               busy_q;

   logic [2:0]     triple;
   logic [EXT-1:0] pp;
   logic [EXT-1:0] upper_sum;
   logic [CW-1:0]  cnt_last;
   logic           last;
   logic [SW-1:0]  shamt;
   logic [ACC-1:0] acc_shift;

   always_comb begin
      triple = {mq_q[1], mq_q[0], lb_q};
      pp     = '0;
      case (triple)
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = -(mcand_q << 1);
         3'b101, 3'b110: pp = -mcand_q;
         default:        pp = '0;
      endcase
      upper_sum = acc_q[ACC-1:EXT] + pp;
   end

   assign cnt_last = signed_q ? CW'(NSGN - 1) : CW'(NUNS - 1);

`ifdef BOOTH_EARLY_TERM_EN
   // Unconsumed bits plus lookahead all equal => every remaining digit is zero.
   logic rest_zero;
   assign rest_zero = (&mq_q[EXT-1:1]) | ~(|mq_q[EXT-1:1]);
   assign last      = (cnt_q == cnt_last) | rest_zero;
`else
   assign last = (cnt_q == cnt_last);
`endif

   // The final step shifts by whatever is left so the product lands at bit 0,
   // i.e. a total right shift of EXT regardless of mode or early exit.
   always_comb begin
      shamt     = last ? (SW'(EXT) - (SW'(cnt_q) << 1)) : SW'(2);
      acc_shift = $signed({upper_sum, acc_q[EXT-1:0]}) >>> shamt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         mq_q     <= '0;
         mcand_q  <= '0;
         lb_q     <= 1'b0;
         signed_q <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else if (bus.op_clear) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.op_start) begin
                  mcand_q  <= bus.op_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                            : {2'b00, bus.multiplicand};
                  mq_q     <= bus.op_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                            : {2'b00, bus.multiplier};
                  signed_q <= bus.op_signed;
                  lb_q     <= 1'b0;
                  cnt_q    <= '0;
                  acc_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StExec;
               end
            end
            StExec: begin
               acc_q <= acc_shift;
               mq_q  <= {mq_q[EXT-1], mq_q[EXT-1], mq_q[EXT-1:2]};
               lb_q  <= mq_q[1];
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  result_q <= acc_shift[2*WIDTH-1:0];
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= StDone;
               end
            end
            StDone: ;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.result  = result_q;
   assign bus.op_done = done_q;
   assign bus.op_busy = busy_q;
endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Scoreboard bench for booth_r4_multiplier (WIDTH=64); expected product and latency
// are queued at start and compared when op_done rises.
module tb_booth_r4_multiplier;
   localparam int unsigned WIDTH = 64;

   typedef struct {
      logic [127:0] prod;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   booth_r4_multiplier_if #(.WIDTH(WIDTH)) bus ();

   booth_r4_multiplier #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model_prod(logic [63:0] a, logic [63:0] b, logic sgn);
      logic [127:0] ae, be;
      ae = sgn ? {{64{a[63]}}, a} : {64'd0, a};
      be = sgn ? {{64{b[63]}}, b} : {64'd0, b};
      return ae * be;
   endfunction

   function automatic int model_lat(logic [63:0] y, logic sgn);
      int          n = sgn ? 32 : 33;
      int          hi = 0;
      logic [66:0] yl;
      logic [2:0]  tr;
      yl = sgn ? {{2{y[63]}}, y, 1'b0} : {2'b00, y, 1'b0};
      for (int i = 0; i < n; i++) begin
         tr = yl[2*i+2 -: 3];
         if (tr != 3'b000 && tr != 3'b111) hi = i;
      end
`ifdef BOOTH_EARLY_TERM_EN
      return hi + 1;
`else
      return (hi >= 0) ? n : n;
`endif
   endfunction

   task automatic drive_idle();
      bus.multiplier   = '0;
      bus.multiplicand = '0;
      bus.op_signed    = 1'b0;
      bus.op_start     = 1'b0;
      bus.op_clear     = 1'b0;
   endtask

   // Present operands, take the start edge, then scramble the inputs.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                           input bit push);
      exp_t e;
      @(negedge clk);
      bus.multiplier   = a;
      bus.multiplicand = b;
      bus.op_signed    = sgn;
      bus.op_start     = 1'b1;
      if (push) begin
         e.prod = model_prod(a, b, sgn);
         e.lat  = model_lat(a, sgn);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.op_start     = 1'b0;
      bus.multiplier   = {$urandom, $urandom};
      bus.multiplicand = {$urandom, $urandom};
      bus.op_signed    = ~sgn;
      check_eq("busy_after_start", {127'd0, bus.op_busy}, 128'd1);
   endtask

   task automatic finish_op(input string tag);
      int   cyc = 0;
      bit   busy_ok = 1'b1;
      exp_t e;
      while (!bus.op_done && cyc < 200) begin
         if (!bus.op_busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq({tag, "_done"}, {127'd0, bus.op_done}, 128'd1);
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 128'd0, 128'd1);
      end else begin
         e = sb.pop_front();
         check_eq({tag, "_result"}, bus.result, e.prod);
         check_eq({tag, "_latency"}, 128'(cyc), 128'(e.lat));
      end
      check_eq({tag, "_busy_span"}, {127'd0, busy_ok}, 128'd1);
      check_eq({tag, "_busy_end"}, {127'd0, bus.op_busy}, 128'd0);
   endtask

   task automatic do_clear(input string tag);
      @(negedge clk);
      bus.op_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.op_clear = 1'b0;
      check_eq({tag, "_clr_result"}, bus.result, 128'd0);
      check_eq({tag, "_clr_done"}, {127'd0, bus.op_done}, 128'd0);
      check_eq({tag, "_clr_busy"}, {127'd0, bus.op_busy}, 128'd0);
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sgn);
      start_op(a, b, sgn, 1'b1);
      finish_op(tag);
      do_clear(tag);
   endtask

   initial begin
      logic [127:0] held;
      exp_t         e;
      drive_idle();
      #12;
      check_eq("reset_result", bus.result, 128'd0);
      check_eq("reset_done", {127'd0, bus.op_done}, 128'd0);
      check_eq("reset_busy", {127'd0, bus.op_busy}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;

      start_op(64'd7, -64'sd7, 1'b1, 1'b1);
      finish_op("s7xm7");
      check_eq("s7xm7_const", bus.result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFCF);
      do_clear("s7xm7");
      run_op("sm159xm753", -64'sd159, -64'sd753, 1'b1);
      run_op("s945x1234", 64'd945, 64'd1234, 1'b1);
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b1);
      finish_op("umaxx2");
      check_eq("umaxx2_const", bus.result, 128'h1_FFFF_FFFF_FFFF_FFFE);
      do_clear("umaxx2");
      run_op("s0x0", 64'd0, 64'd0, 1'b1);
      run_op("smin_x_smin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
      run_op("umax_x_umax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      for (int i = 0; i < 4; i++) begin
         run_op("rand", {$urandom, $urandom}, {$urandom, $urandom}, 1'(i[0]));
      end

      // Abort at cycle 10 of EXEC, then a clean 3 x 5.
      start_op(64'h0123_4567_89AB_CDEF, 64'd987, 1'b1, 1'b0);
      repeat (9) @(posedge clk);
      do_clear("abort");
      run_op("s3x5", 64'd3, 64'd5, 1'b1);

      // op_start held through DONE is ignored; after the clear it starts anew.
      start_op(64'd21, 64'd2, 1'b1, 1'b1);
      finish_op("hold");
      held = model_prod(64'd21, 64'd2, 1'b1);
      @(negedge clk);
      bus.multiplier   = 64'd11;
      bus.multiplicand = 64'd13;
      bus.op_signed    = 1'b1;
      bus.op_start     = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("hold_done", {127'd0, bus.op_done}, 128'd1);
      check_eq("hold_busy", {127'd0, bus.op_busy}, 128'd0);
      check_eq("hold_result", bus.result, held);
      @(negedge clk);
      bus.op_clear = 1'b1;
      @(posedge clk);
      #1;
      check_eq("hold_clr_done", {127'd0, bus.op_done}, 128'd0);
      check_eq("hold_clr_busy", {127'd0, bus.op_busy}, 128'd0);
      e.prod = model_prod(64'd11, 64'd13, 1'b1);
      e.lat  = model_lat(64'd11, 1'b1);
      sb.push_back(e);
      @(negedge clk);
      bus.op_clear = 1'b0;
      @(posedge clk);
      #1;
      bus.op_start = 1'b0;
      check_eq("restart_busy", {127'd0, bus.op_busy}, 128'd1);
      finish_op("restart");
      do_clear("restart");

      // Start and clear on the same edge: clear wins.
      @(negedge clk);
      bus.op_start = 1'b1;
      bus.op_clear = 1'b1;
      @(posedge clk);
      #1;
      bus.op_start = 1'b0;
      bus.op_clear = 1'b0;
      check_eq("same_edge_busy", {127'd0, bus.op_busy}, 128'd0);
      @(posedge clk);
      #1;
      check_eq("same_edge_busy2", {127'd0, bus.op_busy}, 128'd0);
      check_eq("same_edge_done", {127'd0, bus.op_done}, 128'd0);

      // Asynchronous reset in the middle of EXEC.
      start_op(64'hDEAD_BEEF_0000_1111, 64'd77, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("rst_mid_result", bus.result, 128'd0);
      check_eq("rst_mid_done", {127'd0, bus.op_done}, 128'd0);
      check_eq("rst_mid_busy", {127'd0, bus.op_busy}, 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_op("post_rst", 64'd3, 64'd5, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
